pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Each cycle it drives keep/clear
//  for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, multi-cycle mult/div, dmem wait.
// Optional HAZARD_STATS_EN adds saturating stall_cycles_o / flush_count_o statistics outputs.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 4,
    parameter int unsigned STAT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [4:0]        ex_rt_i,
    input  logic              ex_branch_taken_i,
    input  logic              ex_md_start_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_keep_o,
    output logic              ifid_clear_o,
    output logic              idex_keep_o,
    output logic              idex_clear_o,
    output logic              exmem_keep_o,
    output logic              exmem_clear_o,
    output logic              memwb_keep_o,
    output logic              memwb_clear_o,
    output logic [1:0]        state_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles_o,
    output logic [STAT_W-1:0] flush_count_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    assign state_o  = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_o    = 1'b1;
        ifid_keep_o   = 1'b0;
        ifid_clear_o  = 1'b0;
        idex_keep_o   = 1'b0;
        idex_clear_o  = 1'b0;
        exmem_keep_o  = 1'b0;
        exmem_clear_o = 1'b0;
        memwb_keep_o  = 1'b0;
        memwb_clear_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_clear_o  = 1'b1;
            idex_clear_o  = 1'b1;
            exmem_clear_o = 1'b1;
            memwb_clear_o = 1'b1;
        end else if (mem_stall_i) begin
            pc_write_o    = 1'b0;
            ifid_keep_o   = 1'b1;
            idex_keep_o   = 1'b1;
            exmem_keep_o  = 1'b1;
            memwb_clear_o = 1'b1;
        end else begin
            case (state_q)
                MD_BUSY: begin
                    pc_write_o    = 1'b0;
                    ifid_keep_o   = 1'b1;
                    idex_keep_o   = 1'b1;
                    exmem_clear_o = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = MD_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (ex_branch_taken_i) begin
                        ifid_clear_o = 1'b1;
                        idex_clear_o = 1'b1;
                    end else if (ex_md_start_i) begin
                        pc_write_o    = 1'b0;
                        ifid_keep_o   = 1'b1;
                        idex_keep_o   = 1'b1;
                        exmem_clear_o = 1'b1;
                        cnt_d         = MD_LOAD;
                        state_d       = (MD_CYCLES == 2) ? MD_DONE : MD_BUSY;
                    end else if (load_use) begin
                        pc_write_o   = 1'b0;
                        ifid_keep_o  = 1'b1;
                        idex_clear_o = 1'b1;
                    end
                end
                MD_DONE: begin
                    // MD instr leaves EX now; only the load-use check still applies
                    state_d = RUN;
                    if (load_use) begin
                        pc_write_o   = 1'b0;
                        ifid_keep_o  = 1'b1;
                        idex_clear_o = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic flush_fire;
    assign flush_fire = !rst_i && !mem_stall_i && (state_q == RUN) && ex_branch_taken_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (!pc_write_o && (stall_cycles_o != '1))
                stall_cycles_o <= stall_cycles_o + STAT_W'(1);
            if (flush_fire && (flush_count_o != '1))
                flush_count_o <= flush_count_o + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table plus random stimulus vs. a behavioural model.
// Two instances: MD_CYCLES=4/STAT_W=16 and MD_CYCLES=2/STAT_W=2; stats checked when HAZARD_STATS_EN is defined.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] O_DEF = 9'b100000000;
    localparam logic [8:0] O_RST = 9'b001010101;
    localparam logic [8:0] O_LU  = 9'b010010000;
    localparam logic [8:0] O_BR  = 9'b101010000;
    localparam logic [8:0] O_MD  = 9'b010100100;
    localparam logic [8:0] O_MS  = 9'b010101001;

    logic       clk = 1'b0;
    logic       rst, uses, mr, br, md, ms;
    logic [4:0] rs, rt, ert;

    logic [8:0] o_a, o_b;
    logic [1:0] st_a, st_b;
    logic [15:0] sc_a, fc_a;
    logic [1:0]  sc_b, fc_b;

    int checks = 0;
    int errors = 0;

    int md_rem [2];
    int stall_m[2];
    int flush_m[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_CYCLES(4), .STAT_W(16)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses),
        .ex_memread_i(mr), .ex_rt_i(ert), .ex_branch_taken_i(br), .ex_md_start_i(md),
        .mem_stall_i(ms), .pc_write_o(o_a[8]), .ifid_keep_o(o_a[7]), .ifid_clear_o(o_a[6]),
        .idex_keep_o(o_a[5]), .idex_clear_o(o_a[4]), .exmem_keep_o(o_a[3]),
        .exmem_clear_o(o_a[2]), .memwb_keep_o(o_a[1]), .memwb_clear_o(o_a[0]), .state_o(st_a)
`ifdef HAZARD_STATS_EN
        , .stall_cycles_o(sc_a), .flush_count_o(fc_a)
`endif
    );

    pipeline_hazard_ctrl #(.MD_CYCLES(2), .STAT_W(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses),
        .ex_memread_i(mr), .ex_rt_i(ert), .ex_branch_taken_i(br), .ex_md_start_i(md),
        .mem_stall_i(ms), .pc_write_o(o_b[8]), .ifid_keep_o(o_b[7]), .ifid_clear_o(o_b[6]),
        .idex_keep_o(o_b[5]), .idex_clear_o(o_b[4]), .exmem_keep_o(o_b[3]),
        .exmem_clear_o(o_b[2]), .memwb_keep_o(o_b[1]), .memwb_clear_o(o_b[0]), .state_o(st_b)
`ifdef HAZARD_STATS_EN
        , .stall_cycles_o(sc_b), .flush_count_o(fc_b)
`endif
    );

`ifndef HAZARD_STATS_EN
    assign sc_a = '0;
    assign fc_a = '0;
    assign sc_b = '0;
    assign fc_b = '0;
`endif

    typedef struct {
        bit         rst, uses, mr, br, md, ms;
        logic [4:0] rs, rt, ert;
        logic [8:0] eo;
        logic [1:0] est;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [4:0] s, logic [4:0] t, bit u, bit m,
                                logic [4:0] e, bit b, bit d, bit x,
                                logic [8:0] eo, logic [1:0] est);
        vec_t v;
        v.rst = r; v.rs = s; v.rt = t; v.uses = u; v.mr = m; v.ert = e;
        v.br = b; v.md = d; v.ms = x; v.eo = eo; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: md_rem = cycles the MD instr still spends in EX, counting the current one.
    task automatic model_eval(input int k, output logic [8:0] o, output logic [1:0] st,
                              output int nrem, output bit fl);
        int  m;
        bit  lu;
        m    = (k == 0) ? 4 : 2;
        lu   = mr && (ert != 0) && ((ert == rs) || (uses && (ert == rt)));
        o    = O_DEF;
        nrem = md_rem[k];
        fl   = 1'b0;
        st   = (md_rem[k] == 0) ? 2'd0 : (md_rem[k] == 1) ? 2'd2 : 2'd1;
        if (rst) begin
            o = O_RST; nrem = 0;
        end else if (ms) begin
            o = O_MS;
        end else if (md_rem[k] > 1) begin
            o = O_MD; nrem = md_rem[k] - 1;
        end else if (md_rem[k] == 1) begin
            nrem = 0;
            if (lu) o = O_LU;
        end else if (br) begin
            o = O_BR; fl = 1'b1;
        end else if (md) begin
            o = O_MD; nrem = m - 1;
        end else if (lu) begin
            o = O_LU;
        end
    endtask

    task automatic run_cycle(input bit use_tbl, input logic [8:0] t_o, input logic [1:0] t_st,
                             input bit chk_en);
        logic [8:0] mo;
        logic [1:0] mst;
        int         nrem[2];
        int         nst[2];
        int         nfl[2];
        int         smax;
        bit         fl;
        #2;
        for (int k = 0; k < 2; k++) begin
            model_eval(k, mo, mst, nrem[k], fl);
            smax = (k == 0) ? 65535 : 3;
            if (chk_en) begin
                chk($sformatf("outs%0d", k), (k == 0) ? 32'(o_a) : 32'(o_b), 32'(mo));
                chk($sformatf("state%0d", k), (k == 0) ? 32'(st_a) : 32'(st_b), 32'(mst));
`ifdef HAZARD_STATS_EN
                chk($sformatf("stall_cnt%0d", k), (k == 0) ? 32'(sc_a) : 32'(sc_b), 32'(stall_m[k]));
                chk($sformatf("flush_cnt%0d", k), (k == 0) ? 32'(fc_a) : 32'(fc_b), 32'(flush_m[k]));
`endif
            end
            nst[k] = rst ? 0 : (!mo[8] && stall_m[k] < smax) ? stall_m[k] + 1 : stall_m[k];
            nfl[k] = rst ? 0 : (fl && flush_m[k] < smax) ? flush_m[k] + 1 : flush_m[k];
        end
        if (use_tbl) begin
            chk("tbl_outs", 32'(o_a), 32'(t_o));
            chk("tbl_state", 32'(st_a), 32'(t_st));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            md_rem[k]  = nrem[k];
            stall_m[k] = nst[k];
            flush_m[k] = nfl[k];
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; rs = v.rs; rt = v.rt; uses = v.uses; mr = v.mr;
        ert = v.ert; br = v.br; md = v.md; ms = v.ms;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            md_rem[k] = 0; stall_m[k] = 0; flush_m[k] = 0;
        end
        //              rst rs  rt  u mr ert br md ms  outs   st
        tbl.push_back(mk(1, 0,  0,  0, 0, 0,  0, 0, 0, O_RST, 2'd0));
        tbl.push_back(mk(1, 0,  0,  0, 0, 0,  0, 0, 0, O_RST, 2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 0, 0, O_DEF, 2'd0));
        tbl.push_back(mk(0, 8,  0,  0, 1, 8,  0, 0, 0, O_LU,  2'd0));
        tbl.push_back(mk(0, 0,  0,  1, 1, 0,  0, 0, 0, O_DEF, 2'd0));
        tbl.push_back(mk(0, 3,  8,  0, 1, 8,  0, 0, 0, O_DEF, 2'd0));
        tbl.push_back(mk(0, 3,  8,  1, 1, 8,  0, 0, 0, O_LU,  2'd0));
        tbl.push_back(mk(0, 8,  0,  0, 1, 8,  1, 0, 0, O_BR,  2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_MD,  2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_MD,  2'd1));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_MD,  2'd1));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_DEF, 2'd2));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 0, 0, O_DEF, 2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_MD,  2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 1, O_MS,  2'd1));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 1, O_MS,  2'd1));
        tbl.push_back(mk(0, 8,  0,  0, 1, 8,  1, 1, 0, O_MD,  2'd1));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_MD,  2'd1));
        tbl.push_back(mk(0, 8,  0,  0, 1, 8,  1, 1, 0, O_LU,  2'd2));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  1, 0, 0, O_BR,  2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 1, 0, O_MD,  2'd0));
        tbl.push_back(mk(1, 0,  0,  0, 0, 0,  0, 1, 0, O_RST, 2'd1));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 0, 0, O_DEF, 2'd0));
        tbl.push_back(mk(1, 0,  0,  0, 0, 0,  0, 0, 1, O_RST, 2'd0));
        tbl.push_back(mk(0, 0,  0,  0, 0, 0,  0, 0, 0, O_DEF, 2'd0));

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 2'd0));
        @(posedge clk);
        #1;
        run_cycle(1'b0, O_RST, 2'd0, 1'b0);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            run_cycle(1'b1, tbl[i].eo, tbl[i].est, 1'b1);
        end

        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 79) == 0);
            ms   = ($urandom_range(0, 4) == 0);
            br   = ($urandom_range(0, 5) == 0);
            md   = ($urandom_range(0, 3) == 0);
            mr   = ($urandom_range(0, 1) == 1);
            uses = ($urandom_range(0, 1) == 1);
            rs   = 5'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            ert  = 5'($urandom_range(0, 3));
            run_cycle(1'b0, O_DEF, 2'd0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
